// File: rtl/stream_fifo.sv
// Valid/ready elastic buffer of DEPTH beats with optional fall-through bypass,
// synchronous flush, registered occupancy and almost-full status.
module stream_fifo #(
  parameter int DLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int FALLTHRU = 1,
  parameter int AFULL    = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DLEN-1:0]          i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DLEN-1:0]          o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AFULL);

  logic [DLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic            r_active;
  logic            r_afull;

  logic            w_open;
  logic            w_empty;
  logic            w_full;
  logic            w_ihs;
  logic            w_ohs;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_nxt;

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // o_ready never depends on i_ready, and nothing transfers while closed (reset/flush).
  assign w_open  = rstn & r_active & ~i_flush;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_C);

  assign o_ready = w_open & ~w_full;

  always_comb begin
    if (FALLTHRU != 0) begin
      o_valid = w_open & (~w_empty | i_valid);
      o_data  = o_valid ? (w_empty ? i_data : r_mem[r_rd]) : '0;
    end else begin
      o_valid = w_open & ~w_empty;
      o_data  = o_valid ? r_mem[r_rd] : '0;
    end
  end

  assign w_ihs    = i_valid & o_ready;
  assign w_ohs    = o_valid & i_ready;
  // Empty and both sides handshaking in fall-through mode: the beat never touches storage.
  assign w_bypass = (FALLTHRU != 0) & w_empty & w_ihs & w_ohs;
  assign w_push   = w_ihs & ~w_bypass;
  assign w_pop    = w_ohs & ~w_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (i_flush) begin
        r_rd    <= '0;
        r_wr    <= '0;
        r_count <= '0;
        r_afull <= 1'b0;
      end else begin
        if (w_push) r_wr <= r_wr + PW'(1);
        if (w_pop)  r_rd <= r_rd + PW'(1);
        r_count <= w_count_nxt;
        r_afull <= (w_count_nxt >= AF_C);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Status is forced low while reset is asserted, ahead of the clearing edge.
  assign o_count       = rstn ? r_count : '0;
  assign o_almost_full = rstn & r_afull;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: four configurations share one stimulus stream, each
// checked every cycle against a queue-based model of the buffer's contents.
module tb_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        i_flush;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;

  logic        o_ready [4];
  logic        o_valid [4];
  logic        o_afull [4];
  logic [31:0] o_data  [4];
  logic [3:0]  o_cnt   [4];
  logic [2:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [1:0]  cnt_c;
  logic [3:0]  cnt_d;

  assign o_cnt[0] = {1'b0, cnt_a};
  assign o_cnt[1] = {1'b0, cnt_b};
  assign o_cnt[2] = {2'b00, cnt_c};
  assign o_cnt[3] = cnt_d;

  stream_fifo #(.DLEN(32), .DEPTH(4), .FALLTHRU(1), .AFULL(3)) u_ft4 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[0]),
    .i_data(i_data), .o_valid(o_valid[0]), .i_ready(i_ready), .o_data(o_data[0]),
    .o_count(cnt_a), .o_almost_full(o_afull[0]));

  stream_fifo #(.DLEN(32), .DEPTH(4), .FALLTHRU(0), .AFULL(3)) u_rg4 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[1]),
    .i_data(i_data), .o_valid(o_valid[1]), .i_ready(i_ready), .o_data(o_data[1]),
    .o_count(cnt_b), .o_almost_full(o_afull[1]));

  stream_fifo #(.DLEN(32), .DEPTH(2), .FALLTHRU(1), .AFULL(1)) u_ft2 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[2]),
    .i_data(i_data), .o_valid(o_valid[2]), .i_ready(i_ready), .o_data(o_data[2]),
    .o_count(cnt_c), .o_almost_full(o_afull[2]));

  stream_fifo #(.DLEN(32), .DEPTH(8), .FALLTHRU(0), .AFULL(7)) u_rg8 (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready[3]),
    .i_data(i_data), .o_valid(o_valid[3]), .i_ready(i_ready), .o_data(o_data[3]),
    .o_count(cnt_d), .o_almost_full(o_afull[3]));

  function automatic int dep(input int k);
    case (k)
      2:       return 2;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic int ft(input int k);
    return (k == 0 || k == 2) ? 1 : 0;
  endfunction

  function automatic int af(input int k);
    return dep(k) - 1;
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Scoreboard: per-configuration queue of beats accepted and not yet delivered.
  logic [31:0] exp_q [4][$];
  bit          act_m [4];

  always @(negedge clk) begin
    int          sz;
    bit          ev;
    bit          er;
    bit          ihs;
    bit          ohs;
    logic [31:0] ed;
    for (int k = 0; k < 4; k++) begin
      sz = exp_q[k].size();
      if (!rstn || !act_m[k] || i_flush) begin
        er = 1'b0;
        ev = 1'b0;
        ed = '0;
      end else begin
        er = (sz < dep(k));
        ev = (sz > 0) || (ft(k) == 1 && i_valid);
        ed = !ev ? 32'h0 : ((sz > 0) ? exp_q[k][0] : i_data);
      end
      check("o_ready", k, {31'b0, o_ready[k]}, {31'b0, er});
      check("o_valid", k, {31'b0, o_valid[k]}, {31'b0, ev});
      check("o_data", k, o_data[k], ed);
      check("o_count", k, {28'b0, o_cnt[k]}, rstn ? 32'(sz) : 32'h0);
      check("o_almost_full", k, {31'b0, o_afull[k]}, {31'b0, (rstn && sz >= af(k))});

      if (!rstn) begin
        exp_q[k].delete();
        act_m[k] = 1'b0;
      end else if (!act_m[k]) begin
        act_m[k] = 1'b1;
      end else if (i_flush) begin
        exp_q[k].delete();
      end else begin
        ihs = i_valid && er;
        ohs = ev && i_ready;
        if (!(ohs && sz == 0)) begin
          if (ohs) void'(exp_q[k].pop_front());
          if (ihs) exp_q[k].push_back(i_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn    = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    repeat (3) tick();
    rstn = 1'b1;
    @(negedge clk);
    check("first_cycle_ready", 0, {31'b0, o_ready[0]}, 32'h0);
    tick();
    tick();

    // Fill with downstream stalled; the fifth beat stays pending upstream.
    for (int i = 1; i <= 5; i++) begin
      i_valid = 1'b1;
      i_data  = 32'h11 * i;
      tick();
    end
    @(negedge clk);
    check("full_count", 0, {28'b0, o_cnt[0]}, 32'd4);
    check("full_ready", 0, {31'b0, o_ready[0]}, 32'h0);
    check("full_head", 0, o_data[0], 32'h11);
    check("full_afull", 0, {31'b0, o_afull[0]}, 32'h1);

    // Release downstream while 0x55 is still offered.
    tick();
    i_ready = 1'b1;
    @(negedge clk);
    check("drain_c1_ready", 0, {31'b0, o_ready[0]}, 32'h0);
    check("drain_c1_data", 0, o_data[0], 32'h11);
    tick();
    @(negedge clk);
    check("drain_c2_count", 0, {28'b0, o_cnt[0]}, 32'd3);
    check("drain_c2_data", 0, o_data[0], 32'h22);
    tick();
    i_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("drained_count", 0, {28'b0, o_cnt[0]}, 32'd0);
    check("drained_valid", 0, {31'b0, o_valid[0]}, 32'h0);
    check("drained_data", 0, o_data[0], 32'h0);

    // Fall-through bypass, then a stalled beat landing in storage.
    do_reset();
    i_valid = 1'b1;
    i_data  = 32'hAB;
    i_ready = 1'b1;
    @(negedge clk);
    check("bypass_valid", 0, {31'b0, o_valid[0]}, 32'h1);
    check("bypass_data", 0, o_data[0], 32'hAB);
    check("bypass_count", 0, {28'b0, o_cnt[0]}, 32'd0);
    tick();
    i_ready = 1'b0;
    @(negedge clk);
    check("bypass_count_after", 0, {28'b0, o_cnt[0]}, 32'd0);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("stall_count", 0, {28'b0, o_cnt[0]}, 32'd1);
    check("stall_data", 0, o_data[0], 32'hAB);

    // Registered output: one cycle of latency.
    do_reset();
    i_valid = 1'b1;
    i_data  = 32'hCD;
    i_ready = 1'b1;
    @(negedge clk);
    check("reg_valid_n", 1, {31'b0, o_valid[1]}, 32'h0);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("reg_valid_n1", 1, {31'b0, o_valid[1]}, 32'h1);
    check("reg_data_n1", 1, o_data[1], 32'hCD);
    check("reg_count_n1", 1, {28'b0, o_cnt[1]}, 32'd1);
    tick();
    @(negedge clk);
    check("reg_count_n2", 1, {28'b0, o_cnt[1]}, 32'd0);

    // Flush at count 3 with both sides active.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_data  = $urandom;
      tick();
    end
    i_flush = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    check("flush_ready", 0, {31'b0, o_ready[0]}, 32'h0);
    check("flush_valid", 0, {31'b0, o_valid[0]}, 32'h0);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    check("post_flush_count", 0, {28'b0, o_cnt[0]}, 32'd0);
    check("post_flush_afull", 0, {31'b0, o_afull[0]}, 32'h0);
    check("post_flush_ready", 0, {31'b0, o_ready[0]}, 32'h1);

    // Reset mid-operation with two beats stored.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_data  = 32'hE0 + i;
      tick();
    end
    i_valid = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    check("in_reset_count", 0, {28'b0, o_cnt[0]}, 32'd0);
    check("in_reset_valid", 0, {31'b0, o_valid[0]}, 32'h0);
    tick();
    tick();
    rstn    = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    check("release_ready", 0, {31'b0, o_ready[0]}, 32'h0);
    tick();
    @(negedge clk);
    check("release2_ready", 0, {31'b0, o_ready[0]}, 32'h1);
    check("release2_valid", 0, {31'b0, o_valid[0]}, 32'h0);

    // Random traffic with occasional flush and reset.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_data  = $urandom;
      i_flush = ($urandom_range(0, 59) == 0);
      rstn    = ($urandom_range(0, 249) != 0);
      tick();
    end
    rstn    = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      check("final_count", k, {28'b0, o_cnt[k]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
